votingmachine_multi: RTL and testbench

Parametrised successor to the 4-candidate votingmachine. It supports NUM_CAND candidates with CNT_W-bit saturating tallies and press qualification: a vote counts only once the press is held PRESS_CYCLES cycles, and each press counts once. It also rejects multi-button presses. It adds registered winner/tie tracking and a total-vote count. Display mode shows the tally of the selected candidate on led.

---
 rtl/votingmachine_pkg.sv | 42 ++++
 rtl/vm_press_qualifier.sv | 138 +++++++++++++
 rtl/votingmachine_multi.sv | 129 ++++++++++++
 tb/tb_votingmachine_multi.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/votingmachine_pkg.sv
// Shared definitions for the parametrised voting machine.
//   - press_state_e : press-qualification FSM states
//   - DEF_*         : default parameter values
//   - onehot_check  : classifies a button pattern as one-hot (valid) and
//                     returns the index of the pressed button
package votingmachine_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL     = 2'd1,
    REJECT   = 2'd2,
    WAIT_REL = 2'd3
  } press_state_e;

  localparam int DEF_NUM_CAND     = 4;
  localparam int DEF_CNT_W        = 8;
  localparam int DEF_PRESS_CYCLES = 2;

  // Widest button vector the helper handles; callers zero-extend into it.
  localparam int MAX_CAND = 16;

  typedef struct packed {
    logic       valid;  // exactly one bit set
    logic [3:0] idx;    // index of the set bit (meaningful only when valid)
  } onehot_t;

  function automatic onehot_t onehot_check(input logic [MAX_CAND-1:0] pat);
    onehot_t res;
    int      n_set;
    res   = '0;
    n_set = 0;
    for (int i = 0; i < MAX_CAND; i++) begin
      if (pat[i]) begin
        n_set++;
        res.idx = 4'(i);
      end
    end
    res.valid = (n_set == 1);
    return res;
  endfunction

endpackage

// File: rtl/vm_press_qualifier.sv
// Press qualification FSM for the voting machine.
// A one-hot button pattern must be held stable PRESS_CYCLES consecutive
// cycles to qualify; each press qualifies at most once, multi-hot presses
// are rejected, and a mode toggle during qualification aborts the press.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_mode       : 0 = voting, 1 = display
//   i_button     : level-sensitive candidate buttons
//   o_qual       : one-cycle pulse, a press has qualified
//   o_qual_mode  : mode the press qualified in (valid with o_qual)
//   o_qual_idx   : candidate index of the qualified press
//   o_err        : one-cycle pulse, a multi-hot press was rejected
module vm_press_qualifier
  import votingmachine_pkg::*;
#(
  parameter int NUM_CAND     = DEF_NUM_CAND,
  parameter int PRESS_CYCLES = DEF_PRESS_CYCLES,
  parameter int IDX_W        = $clog2(NUM_CAND)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_mode,
  input  logic [NUM_CAND-1:0] i_button,
  output logic                o_qual,
  output logic                o_qual_mode,
  output logic [IDX_W-1:0]    o_qual_idx,
  output logic                o_err
);

  localparam int HOLD_W = $clog2(PRESS_CYCLES + 1);

  press_state_e        r_state,    w_state_nx;
  logic [HOLD_W-1:0]   r_hold,     w_hold_nx;
  logic [NUM_CAND-1:0] r_pat,      w_pat_nx;
  logic                r_mode_lat, w_mode_nx;
  logic                r_armed;
  logic                r_qual,     w_fire;
  logic                r_qual_mode;
  logic [IDX_W-1:0]    r_qual_idx;

  logic [MAX_CAND-1:0] w_btn_ext;
  onehot_t             w_oh;
  logic [IDX_W-1:0]    w_oh_idx;

  assign w_btn_ext = MAX_CAND'(i_button);
  assign w_oh      = onehot_check(w_btn_ext);
  assign w_oh_idx  = IDX_W'(w_oh.idx);

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps this combinational block from
  // inferring latches.
  always_comb begin
    w_state_nx = r_state;
    w_hold_nx  = r_hold;
    w_pat_nx   = r_pat;
    w_mode_nx  = r_mode_lat;
    w_fire     = 1'b0;
    unique case (r_state)
      IDLE: begin
        // r_armed blocks a button that was already down when reset released.
        if (r_armed && (i_button != '0)) begin
          if (w_oh.valid) begin
            w_pat_nx  = i_button;
            w_mode_nx = i_mode;
            if (PRESS_CYCLES == 1) begin
              w_fire     = 1'b1;
              w_hold_nx  = '0;
              w_state_nx = WAIT_REL;
            end else begin
              w_hold_nx  = HOLD_W'(1);
              w_state_nx = QUAL;
            end
          end else begin
            w_state_nx = REJECT;
          end
        end
      end
      QUAL: begin
        // Mode is looked at before the button so a toggle always aborts.
        if (i_mode != r_mode_lat) begin
          w_hold_nx  = '0;
          w_state_nx = WAIT_REL;
        end else if (i_button == '0) begin
          w_hold_nx  = '0;
          w_state_nx = IDLE;
        end else if (!w_oh.valid) begin
          w_hold_nx  = '0;
          w_state_nx = REJECT;
        end else if (i_button != r_pat) begin
          w_pat_nx  = i_button;
          w_hold_nx = HOLD_W'(1);
        end else if (r_hold == HOLD_W'(PRESS_CYCLES - 1)) begin
          w_fire     = 1'b1;
          w_hold_nx  = '0;
          w_state_nx = WAIT_REL;
        end else begin
          w_hold_nx = r_hold + HOLD_W'(1);
        end
      end
      REJECT:   w_state_nx = WAIT_REL;
      WAIT_REL: if (i_button == '0) w_state_nx = IDLE;
      default:  w_state_nx = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_hold      <= '0;
      r_pat       <= '0;
      r_mode_lat  <= 1'b0;
      r_armed     <= 1'b0;
      r_qual      <= 1'b0;
      r_qual_mode <= 1'b0;
      r_qual_idx  <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_hold     <= w_hold_nx;
      r_pat      <= w_pat_nx;
      r_mode_lat <= w_mode_nx;
      if (i_button == '0) r_armed <= 1'b1;
      r_qual     <= w_fire;
      if (w_fire) begin
        r_qual_mode <= i_mode;
        r_qual_idx  <= w_oh_idx;
      end
    end
  end

  assign o_qual      = r_qual;
  assign o_qual_mode = r_qual_mode;
  assign o_qual_idx  = r_qual_idx;
  // REJECT lasts exactly one cycle, so the state decode is the error pulse.
  assign o_err       = (r_state == REJECT);

endmodule

// File: rtl/votingmachine_multi.sv
// Parametrised voting machine: NUM_CAND candidates, saturating CNT_W-bit
// tallies, qualified presses, registered winner/tie/total and a display mode.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   mode          : 0 = voting, 1 = display
//   button        : candidate buttons (bit i = candidate i)
//   led           : tally of the selected candidate in display mode, else 0
//   vote_ack      : one-cycle pulse per recorded vote (also when saturated)
//   vote_err      : one-cycle pulse per rejected multi-hot press
//   winner        : lowest index holding the maximum tally
//   winner_valid  : total > 0
//   tie           : maximum shared by two or more candidates (total > 0)
//   total         : sum of all tallies
module votingmachine_multi
  import votingmachine_pkg::*;
#(
  parameter int NUM_CAND     = DEF_NUM_CAND,
  parameter int CNT_W        = DEF_CNT_W,
  parameter int PRESS_CYCLES = DEF_PRESS_CYCLES
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                mode,
  input  logic [NUM_CAND-1:0]                 button,
  output logic [CNT_W-1:0]                    led,
  output logic                                vote_ack,
  output logic                                vote_err,
  output logic [$clog2(NUM_CAND)-1:0]         winner,
  output logic                                winner_valid,
  output logic                                tie,
  output logic [CNT_W+$clog2(NUM_CAND)-1:0]   total
);

  localparam int IDX_W = $clog2(NUM_CAND);
  localparam int TOT_W = CNT_W + IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_qual, w_qual_mode, w_err;
  logic [IDX_W-1:0] w_qual_idx;

  vm_press_qualifier #(
    .NUM_CAND    (NUM_CAND),
    .PRESS_CYCLES(PRESS_CYCLES),
    .IDX_W       (IDX_W)
  ) u_press (
    .clk        (clk),
    .rst_n      (reset),
    .i_mode     (mode),
    .i_button   (button),
    .o_qual     (w_qual),
    .o_qual_mode(w_qual_mode),
    .o_qual_idx (w_qual_idx),
    .o_err      (w_err)
  );

  logic [CNT_W-1:0] r_tally [NUM_CAND];
  logic [IDX_W-1:0] r_sel;
  logic [CNT_W-1:0] r_led;
  logic             r_vote_ack;

  // NOTE: the tally array is reset explicitly, element by element; it holds
  // live results, so it must be flops cleared by reset rather than a RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CAND; i++) r_tally[i] <= '0;
      r_sel      <= '0;
      r_led      <= '0;
      r_vote_ack <= 1'b0;
    end else begin
      r_vote_ack <= w_qual && !w_qual_mode;
      if (w_qual && !w_qual_mode && (r_tally[w_qual_idx] != CNT_MAX))
        r_tally[w_qual_idx] <= r_tally[w_qual_idx] + CNT_W'(1);
      if (w_qual && w_qual_mode)
        r_sel <= w_qual_idx;
      r_led <= mode ? r_tally[r_sel] : '0;
    end
  end

  // Max / lowest-index winner / tie count / sum over the current tallies.
  logic [CNT_W-1:0] w_max;
  logic [IDX_W-1:0] w_win;
  logic [TOT_W-1:0] w_sum;
  int               w_n_max;

  always_comb begin
    w_max   = '0;
    w_win   = '0;
    w_sum   = '0;
    w_n_max = 0;
    for (int i = 0; i < NUM_CAND; i++) begin
      w_sum = w_sum + TOT_W'(r_tally[i]);
      // Strict '>' keeps the lowest index when the maximum is shared.
      if (r_tally[i] > w_max) begin
        w_max = r_tally[i];
        w_win = IDX_W'(i);
      end
    end
    for (int i = 0; i < NUM_CAND; i++) begin
      if (r_tally[i] == w_max) w_n_max++;
    end
  end

  logic [IDX_W-1:0] r_winner;
  logic             r_winner_valid, r_tie;
  logic [TOT_W-1:0] r_total;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_winner       <= '0;
      r_winner_valid <= 1'b0;
      r_tie          <= 1'b0;
      r_total        <= '0;
    end else begin
      r_winner       <= w_win;
      r_winner_valid <= (w_sum != '0);
      r_tie          <= (w_sum != '0) && (w_n_max > 1);
      r_total        <= w_sum;
    end
  end

  assign led          = r_led;
  assign vote_ack     = r_vote_ack;
  assign vote_err     = w_err;
  assign winner       = r_winner;
  assign winner_valid = r_winner_valid;
  assign tie          = r_tie;
  assign total        = r_total;

endmodule

// File: tb/tb_votingmachine_multi.sv
// Directed bench for votingmachine_multi: a default build (4 candidates,
// 8-bit tallies, 2-cycle qualification) and a CNT_W=2 build for saturation.
module tb_votingmachine_multi;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode,  mode2;
  logic [3:0] button, button2;

  logic [7:0] led;
  logic       vote_ack, vote_err, winner_valid, tie;
  logic [1:0] winner;
  logic [9:0] total;

  logic [1:0] led2;
  logic       vote_ack2, vote_err2, winner_valid2, tie2;
  logic [1:0] winner2;
  logic [3:0] total2;

  int n_checks = 0;
  int n_pass   = 0;
  int ack_cnt  = 0;
  int err_cnt  = 0;
  int ack2_cnt = 0;

  always #5 clk = ~clk;

  votingmachine_multi dut (
    .clk(clk), .reset(reset), .mode(mode), .button(button),
    .led(led), .vote_ack(vote_ack), .vote_err(vote_err),
    .winner(winner), .winner_valid(winner_valid), .tie(tie), .total(total)
  );

  votingmachine_multi #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .mode(mode2), .button(button2),
    .led(led2), .vote_ack(vote_ack2), .vote_err(vote_err2),
    .winner(winner2), .winner_valid(winner_valid2), .tie(tie2), .total(total2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // One clock: inputs set before this are sampled at the edge; outputs are
  // read 1 ns later and pulse outputs are accumulated.
  task automatic cyc();
    @(posedge clk);
    #1;
    ack_cnt  += int'(vote_ack);
    err_cnt  += int'(vote_err);
    ack2_cnt += int'(vote_ack2);
  endtask

  task automatic press(input logic [3:0] p, input int n);
    button = p;
    repeat (n) cyc();
  endtask

  task automatic rel(input int n);
    button = 4'b0000;
    repeat (n) cyc();
  endtask

  task automatic vote(input logic [3:0] p);
    press(p, 3);
    rel(4);
  endtask

  task automatic vote2(input logic [3:0] p);
    button2 = p;
    repeat (3) cyc();
    button2 = 4'b0000;
    repeat (4) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; mode = 1'b0; mode2 = 1'b0; button = '0; button2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led",    led, 0);
    check("rst_ack",    vote_ack, 0);
    check("rst_err",    vote_err, 0);
    check("rst_winner", winner, 0);
    check("rst_valid",  winner_valid, 0);
    check("rst_tie",    tie, 0);
    check("rst_total",  total, 0);
    reset = 1'b1;
    repeat (2) cyc();

    // c0 held 3 cycles: one vote
    ack_cnt = 0;
    press(4'b0001, 3); rel(4);
    check("t1_ack",    ack_cnt, 1);
    check("t1_total",  total, 1);
    check("t1_winner", winner, 0);
    check("t1_valid",  winner_valid, 1);
    check("t1_tie",    tie, 0);

    // c1 held only 1 cycle: too short
    ack_cnt = 0;
    press(4'b0010, 1); rel(4);
    check("short_ack",   ack_cnt, 0);
    check("short_total", total, 1);

    // c1 held 50 cycles: exactly one vote, c0/c1 tie
    ack_cnt = 0;
    press(4'b0010, 50); rel(4);
    check("long_ack",    ack_cnt, 1);
    check("long_total",  total, 2);
    check("long_tie",    tie, 1);
    check("long_winner", winner, 0);

    // multi-hot rejected, then one-hot without release: nothing counts
    ack_cnt = 0; err_cnt = 0;
    press(4'b0101, 2);
    press(4'b0100, 2);
    rel(4);
    check("rej_err",   err_cnt, 1);
    check("rej_ack",   ack_cnt, 0);
    check("rej_total", total, 2);
    vote(4'b0100);
    check("repress_ack",   ack_cnt, 1);
    check("repress_total", total, 3);

    // build c0=3 c1=1 c2=1 c3=2
    ack_cnt = 0;
    vote(4'b0001); vote(4'b0001); vote(4'b1000); vote(4'b1000);
    check("mix_ack",    ack_cnt, 4);
    check("mix_total",  total, 7);
    check("mix_winner", winner, 0);
    check("mix_tie",    tie, 0);

    // display mode
    ack_cnt = 0;
    mode = 1'b1;
    press(4'b1000, 2); rel(4);
    check("disp_c3",      led, 2);
    check("disp_ack",     ack_cnt, 0);
    check("disp_total",   total, 7);
    press(4'b0001, 3); rel(4);
    check("disp_c0",      led, 3);
    mode = 1'b0;
    cyc();
    check("vote_mode_led", led, 0);

    // mode toggle during qualification aborts the press
    ack_cnt = 0;
    press(4'b0010, 1);
    mode = 1'b1;
    press(4'b0010, 3);
    rel(4);
    check("abort_ack",   ack_cnt, 0);
    check("abort_total", total, 7);
    check("abort_led",   led, 3);
    mode = 1'b0;
    cyc();

    // c3 catches up (tie), then overtakes
    vote(4'b1000);
    check("tie3_tie",    tie, 1);
    check("tie3_winner", winner, 0);
    check("tie3_total",  total, 8);
    vote(4'b1000);
    check("lead3_tie",    tie, 0);
    check("lead3_winner", winner, 3);
    check("lead3_total",  total, 9);

    // saturation on the CNT_W=2 build
    ack2_cnt = 0;
    repeat (5) vote2(4'b0100);
    check("sat_ack",    ack2_cnt, 5);
    check("sat_total",  total2, 3);
    check("sat_winner", winner2, 2);
    check("sat_valid",  winner_valid2, 1);
    check("sat_tie",    tie2, 0);
    mode2 = 1'b1;
    vote2(4'b0100);
    check("sat_led",    led2, 3);

    // reset in the middle of a press
    mode = 1'b0;
    button = 4'b0001;
    cyc();
    reset = 1'b0;
    #1;
    check("mid_rst_total",  total, 0);
    check("mid_rst_valid",  winner_valid, 0);
    check("mid_rst_winner", winner, 0);
    check("mid_rst_ack",    vote_ack, 0);
    check("mid_rst_err",    vote_err, 0);
    check("mid_rst_tie",    tie, 0);
    check("mid_rst_led",    led, 0);
    check("mid_rst_total2", total2, 0);
    @(negedge clk);
    reset = 1'b1;
    ack_cnt = 0;
    repeat (5) cyc();
    check("post_rst_ack",   ack_cnt, 0);
    check("post_rst_total", total, 0);
    rel(4);
    vote(4'b0001);
    check("post_rst_vote_ack",   ack_cnt, 1);
    check("post_rst_vote_total", total, 1);
    check("post_rst_valid",      winner_valid, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
